mux_nx1_stream: RTL
===================

Name: mux_nx1_stream

Overview:
Parametrised, registered N:1 data multiplexer with a valid/ready stream handshake. It is the next generation of the 16x1 32-bit mux and adds width/depth generality, output backpressure, and a round-robin auto-scan mode over a channel-enable mask. It sits between a bank of DEPTH parallel data sources and a single downstream consumer. It uses one clock domain.

Parameters:
WIDTH, 32, data width of each input channel and of cout
DEPTH, 16, number of input channels (>=2, need not be a power of two)
SEL_W, $clog2(DEPTH), select/channel-index width (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
din  input  DEPTH*WIDTH  packed channels; channel k = din[k*WIDTH +: WIDTH]
s  input  SEL_W  channel select, used in direct mode only
mode  input  1  0 = direct (select by s), 1 = scan (round-robin over ch_mask)
ch_mask  input  DEPTH  per-channel enable, used in scan mode only
in_valid  input  1  request to sample one channel this cycle
in_ready  output  1  block can accept a sample this cycle
cout  output  WIDTH  registered selected data
cout_ch  output  SEL_W  index of the channel captured in cout
cout_err  output  1  captured sample came from an out-of-range select
cout_valid  output  1  cout/cout_ch/cout_err hold a valid sample
cout_ready  input  1  downstream accepts the sample

Behaviour:
- Reset: synchronous, active-high. At the clk edge where rst=1: cout=0, cout_ch=0, cout_err=0, cout_valid=0, scan_ptr=0. rst overrides any accept in the same cycle, and a pending sample is discarded.
- Output stage: one-entry register.
  - in_ready = (!cout_valid || cout_ready) && !(mode && ch_mask==0), combinational.
  - Accept happens when in_valid && in_ready.
- Latency: 1 cycle. The sample taken from din at the accept edge appears on cout with cout_valid=1 in the next cycle.
- Throughput: 1 sample per cycle when cout_ready is held high. Accept and drain may occur in the same cycle, and the new sample replaces the old one.
- Backpressure: while cout_valid && !cout_ready, cout/cout_ch/cout_err hold stable and in_ready=0.
- Drain without accept: cout_valid && cout_ready && no accept -> cout_valid=0. cout/cout_ch/cout_err keep their last values.
- Direct mode (mode=0):
  - s < DEPTH: capture din[s], cout_ch=s, cout_err=0.
  - s >= DEPTH (only possible when DEPTH is not a power of two): capture cout=0, cout_ch=s, cout_err=1.
  - scan_ptr is not modified.
- Scan mode (mode=1):
  - Pick = first index i with ch_mask[i]=1, searching scan_ptr, scan_ptr+1, ... modulo DEPTH.
  - Capture din[pick], cout_ch=pick, cout_err=0.
  - Then scan_ptr = (pick==DEPTH-1) ? 0 : pick+1.
- Scan with ch_mask==0: in_ready=0, no accept, scan_ptr unchanged. Any pending output still drains normally.
- ch_mask changes take effect on the next accept; no sample is lost or duplicated.
- Mode switches are legal on any cycle. scan_ptr is retained across direct-mode periods.
- din, s, mode, ch_mask are sampled only at accept edges; values in other cycles have no effect.

Decomposition:
- Package mux_nx1_pkg:
  - typedef enum logic {MODE_DIRECT=1'b0, MODE_SCAN=1'b1} mux_mode_e
  - helper function for the SEL_W calculation.
- Sub-module rr_pick (parameter DEPTH):
  - inputs: mask, start index
  - outputs: pick index, any_set
  - purely combinational rotate + priority-find. Instantiated once in the datapath.

Test Plan:
- Direct sweep: WIDTH=32, DEPTH=16, din[k]=32'hA000_0000+k, cout_ready=1, in_valid=1, s=0..15 on consecutive cycles -> cout=A000_0000..A000_000F one cycle later, back-to-back, cout_ch=s, cout_err=0.
- Backpressure: accept s=3, then hold cout_ready=0 for 4 cycles while s changes -> cout stays A000_0003, in_ready=0. Raise cout_ready with s=7 -> next cycle cout=A000_0007, with no drop or duplicate.
- Scan wrap: mode=1, ch_mask=16'h8005, 5 accepts -> cout_ch sequence 0, 2, 15, 0, 2. Final scan_ptr=3.
- Empty mask: mode=1, ch_mask=0, in_valid=1 for 3 cycles -> in_ready=0, no cout_valid rise. Set ch_mask=16'h0010 -> next accept gives cout_ch=4.
- Out-of-range select: DEPTH=10 (SEL_W=4), s=12 -> cout=0, cout_ch=12, cout_err=1. Then s=9 -> cout=din[9], cout_err=0.
- Reset mid-stream: scan mode with cout_valid=1 and scan_ptr=5; assert rst for 1 cycle alongside in_valid=1 -> next cycle cout_valid=0, cout=0, no accept. The first scan accept after reset starts from index 0.

Source files
------------

// File: rtl/mux_nx1_pkg.sv
// Shared types and width helpers for the N:1 stream multiplexer.
package mux_nx1_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mux_mode_e;

  // A single-channel index still needs one bit of select.
  function automatic int sel_width(input int depth);
    if (depth <= 1) begin
      return 1;
    end else begin
      return $clog2(depth);
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set mask bit at or after start, wrapping modulo DEPTH.
module rr_pick
  import mux_nx1_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int SEL_W = sel_width(DEPTH)
) (
  input  logic [DEPTH-1:0] mask,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] pick,
  output logic             any_set
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    logic [SEL_W:0]   sum_s;
    logic [SEL_W-1:0] idx_s;
    pick    = {SEL_W{1'b0}};
    any_set = |mask;
    sum_s   = {(SEL_W+1){1'b0}};
    idx_s   = {SEL_W{1'b0}};
    for (int off = DEPTH - 1; off >= 0; off--) begin
      sum_s = {1'b0, start} + (SEL_W+1)'(off);
      if (sum_s >= (SEL_W+1)'(DEPTH)) begin
        sum_s = sum_s - (SEL_W+1)'(DEPTH);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[SEL_W-1:0];
      if (mask[idx_s]) begin
        pick = idx_s;
      end else begin
        pick = pick;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// Registered N:1 multiplexer with valid/ready output stage and round-robin scan mode.
module mux_nx1_stream
  import mux_nx1_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int SEL_W = sel_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DEPTH*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]       s,
  input  logic                   mode,
  input  logic [DEPTH-1:0]       ch_mask,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       cout,
  output logic [SEL_W-1:0]       cout_ch,
  output logic                   cout_err,
  output logic                   cout_valid,
  input  logic                   cout_ready
);

  mux_mode_e        mode_s;
  logic [SEL_W-1:0] scan_ptr_r;
  logic [SEL_W-1:0] pick_s;
  logic             any_set_s;
  logic [SEL_W-1:0] sel_idx_s;
  logic             in_range_s;
  logic [WIDTH-1:0] sel_data_s;
  logic [SEL_W-1:0] next_ptr_s;
  logic             accept_s;

  assign mode_s = mux_mode_e'(mode);

  rr_pick #(
    .DEPTH (DEPTH)
  ) u_rr_pick (
    .mask    (ch_mask),
    .start   (scan_ptr_r),
    .pick    (pick_s),
    .any_set (any_set_s)
  );

  // A scan request with nothing enabled must not be accepted.
  assign in_ready = (!cout_valid || cout_ready) && !((mode_s == MODE_SCAN) && !any_set_s);
  assign accept_s = in_valid && in_ready;

  assign next_ptr_s = (pick_s == SEL_W'(DEPTH - 1)) ? {SEL_W{1'b0}} : pick_s + SEL_W'(1);

  // Choose the channel index for this accept and flag selects past the last channel.
  always_comb begin
    sel_idx_s  = s;
    in_range_s = 1'b1;
    case (mode_s)
      MODE_SCAN: begin
        sel_idx_s  = pick_s;
        in_range_s = 1'b1;
      end
      MODE_DIRECT: begin
        sel_idx_s  = s;
        in_range_s = ({1'b0, s} < (SEL_W+1)'(DEPTH));
      end
      default: begin
        sel_idx_s  = s;
        in_range_s = ({1'b0, s} < (SEL_W+1)'(DEPTH));
      end
    endcase
  end

  // AND-OR data select; an out-of-range index matches no channel and yields zero.
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      sel_data_s = sel_data_s |
                   (din[k*WIDTH +: WIDTH] & {WIDTH{(sel_idx_s == SEL_W'(k))}});
    end
  end

  // Output register and scan pointer; drain clears only the valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cout       <= {WIDTH{1'b0}};
      cout_ch    <= {SEL_W{1'b0}};
      cout_err   <= 1'b0;
      cout_valid <= 1'b0;
      scan_ptr_r <= {SEL_W{1'b0}};
    end else if (accept_s) begin
      cout       <= sel_data_s;
      cout_ch    <= sel_idx_s;
      cout_err   <= !in_range_s;
      cout_valid <= 1'b1;
      if (mode_s == MODE_SCAN) begin
        scan_ptr_r <= next_ptr_s;
      end else begin
        scan_ptr_r <= scan_ptr_r;
      end
    end else if (cout_ready) begin
      cout_valid <= 1'b0;
    end else begin
      cout_valid <= cout_valid;
    end
  end

endmodule
